pkt_mem_agent: RTL and testbench

Avalon-MM burst-capable memory agent (responder) that terminates the capture engine's read-host and write-host ports in simulation and in on-chip loopback builds. It owns a single-port word RAM and serves burst reads with `readdatavalid` and burst writes with `waitrequest` back-pressure. Its configurable command-acceptance delay exercises the hosts' stall handling. Two beat counters and a sticky protocol-error flag feed the register bank for debug.

---
 rtl/pkt_mem_agent_if.sv | 24 ++
 rtl/pkt_mem_agent.sv | 126 ++++++++++++
 tb/tb_pkt_mem_agent.sv | 310 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pkt_mem_agent_if.sv
// Avalon-MM bus between a burst-capable host and the pkt_mem_agent responder.
// Handshake: a command or write beat transfers on a rising edge where the host holds
// avs_read/avs_write high and avs_waitrequest is low; read beats return with avs_readdatavalid
// and are never back-pressured.
interface pkt_mem_agent_if;
  logic [31:0] avs_address;
  logic        avs_read;
  logic        avs_write;
  logic [31:0] avs_writedata;
  logic [15:0] avs_burstcount;
  logic        avs_waitrequest;
  logic [31:0] avs_readdata;
  logic        avs_readdatavalid;

  modport master (
    output avs_address, avs_read, avs_write, avs_writedata, avs_burstcount,
    input  avs_waitrequest, avs_readdata, avs_readdatavalid
  );

  modport slave (
    input  avs_address, avs_read, avs_write, avs_writedata, avs_burstcount,
    output avs_waitrequest, avs_readdata, avs_readdatavalid
  );
endinterface

// File: rtl/pkt_mem_agent.sv
// Avalon-MM burst memory responder: single-port word RAM, burst reads/writes,
// programmable command-acceptance delay, beat counters and a sticky protocol-error flag.
module pkt_mem_agent #(
  parameter int AW_WORDS    = 10,
  parameter int WAIT_STATES = 0
) (
  input  logic           clk,
  input  logic           reset,
  pkt_mem_agent_if.slave bus,
  output logic [31:0]    beats_written,
  output logic [31:0]    beats_read,
  output logic           proto_err,
  output logic [1:0]     state_dbg
);
  typedef enum logic [1:0] {
    S_WAIT = 2'd0,
    S_IDLE = 2'd1,
    S_WR   = 2'd2,
    S_RD   = 2'd3
  } state_t;

  localparam int                  DEPTH     = 1 << AW_WORDS;
  localparam bit                  HAS_WAIT  = (WAIT_STATES != 0);
  localparam logic [3:0]          WAIT_INIT = 4'(WAIT_STATES);
  // After a burst the WAIT cycles are counted from the final beat, so one fewer is loaded.
  localparam logic [3:0]          WAIT_GAP  = HAS_WAIT ? 4'(WAIT_STATES - 1) : 4'd0;
  localparam state_t              AFTER_CMD = HAS_WAIT ? S_WAIT : S_IDLE;
  localparam logic [AW_WORDS-1:0] ADDR_ONE  = AW_WORDS'(1);

  logic [31:0]         mem [DEPTH];
  state_t              state;
  logic [3:0]          wait_cnt;
  logic [AW_WORDS-1:0] base;
  logic [15:0]         remaining;
  logic [AW_WORDS-1:0] idx;
  logic [15:0]         burst_n;
  logic                wr_fire;
  logic [AW_WORDS-1:0] wr_addr;
  logic                unused_addr_bits;

  assign idx              = bus.avs_address[AW_WORDS+1:2];
  assign burst_n          = (bus.avs_burstcount == 16'd0) ? 16'd1 : bus.avs_burstcount;
  assign unused_addr_bits = ^{bus.avs_address[31:AW_WORDS+2], bus.avs_address[1:0]};
  assign state_dbg        = state;

  // A write beat lands either as the opening beat of a command in IDLE or as a burst beat.
  assign wr_fire = bus.avs_write && !bus.avs_waitrequest &&
                   ((state == S_IDLE && !bus.avs_read) || state == S_WR);
  assign wr_addr = (state == S_IDLE) ? idx : base;

  always_ff @(posedge clk) begin
    if (wr_fire) mem[wr_addr] <= bus.avs_writedata;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state                 <= S_WAIT;
      wait_cnt              <= WAIT_INIT;
      base                  <= '0;
      remaining             <= '0;
      bus.avs_waitrequest   <= 1'b1;
      bus.avs_readdatavalid <= 1'b0;
      bus.avs_readdata      <= '0;
      beats_written         <= '0;
      beats_read            <= '0;
      proto_err             <= 1'b0;
    end else begin
      bus.avs_readdatavalid <= 1'b0;
      if (wr_fire) beats_written <= beats_written + 32'd1;
      case (state)
        S_WAIT: begin
          if (wait_cnt == 4'd0) begin
            state               <= S_IDLE;
            bus.avs_waitrequest <= 1'b0;
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end
        S_IDLE: begin
          if (bus.avs_read && bus.avs_write) begin
            proto_err <= 1'b1;
          end else if (bus.avs_write) begin
            base      <= idx + ADDR_ONE;
            remaining <= burst_n - 16'd1;
            if (burst_n == 16'd1) begin
              state               <= AFTER_CMD;
              wait_cnt            <= WAIT_GAP;
              bus.avs_waitrequest <= HAS_WAIT;
            end else begin
              state <= S_WR;
            end
          end else if (bus.avs_read) begin
            base                <= idx;
            remaining           <= burst_n;
            state               <= S_RD;
            bus.avs_waitrequest <= 1'b1;
          end
        end
        S_WR: begin
          if (bus.avs_write) begin
            base      <= base + ADDR_ONE;
            remaining <= remaining - 16'd1;
            if (remaining == 16'd1) begin
              state               <= AFTER_CMD;
              wait_cnt            <= WAIT_GAP;
              bus.avs_waitrequest <= HAS_WAIT;
            end
          end
        end
        S_RD: begin
          bus.avs_readdata      <= mem[base];
          bus.avs_readdatavalid <= 1'b1;
          beats_read            <= beats_read + 32'd1;
          base                  <= base + ADDR_ONE;
          remaining             <= remaining - 16'd1;
          if (remaining == 16'd1) begin
            state               <= AFTER_CMD;
            wait_cnt            <= WAIT_GAP;
            bus.avs_waitrequest <= HAS_WAIT;
          end
        end
        default: state <= S_WAIT;
      endcase
    end
  end
endmodule

// File: tb/tb_pkt_mem_agent.sv
// Bench for pkt_mem_agent: three instances (default, 16-word RAM, 3 wait states) driven by
// directed bursts and checked every cycle against a cycle-stamped transaction model.
module tb_pkt_mem_agent;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [31:0] a_addr [3];
  logic        a_rd   [3];
  logic        a_wr   [3];
  logic [31:0] a_wd   [3];
  logic [15:0] a_bc   [3];
  logic        o_wreq [3];
  logic        o_rdv  [3];
  logic [31:0] o_rdata[3];
  logic [31:0] o_bw   [3];
  logic [31:0] o_br   [3];
  logic        o_perr [3];
  logic [1:0]  o_state[3];

  int     n_cmp = 0;
  int     n_err = 0;
  longint cyc   = 0;

  pkt_mem_agent_if bus0 ();
  pkt_mem_agent_if bus1 ();
  pkt_mem_agent_if bus2 ();

  assign bus0.avs_address = a_addr[0]; assign bus0.avs_read = a_rd[0]; assign bus0.avs_write = a_wr[0];
  assign bus0.avs_writedata = a_wd[0]; assign bus0.avs_burstcount = a_bc[0];
  assign o_wreq[0] = bus0.avs_waitrequest; assign o_rdv[0] = bus0.avs_readdatavalid; assign o_rdata[0] = bus0.avs_readdata;
  assign bus1.avs_address = a_addr[1]; assign bus1.avs_read = a_rd[1]; assign bus1.avs_write = a_wr[1];
  assign bus1.avs_writedata = a_wd[1]; assign bus1.avs_burstcount = a_bc[1];
  assign o_wreq[1] = bus1.avs_waitrequest; assign o_rdv[1] = bus1.avs_readdatavalid; assign o_rdata[1] = bus1.avs_readdata;
  assign bus2.avs_address = a_addr[2]; assign bus2.avs_read = a_rd[2]; assign bus2.avs_write = a_wr[2];
  assign bus2.avs_writedata = a_wd[2]; assign bus2.avs_burstcount = a_bc[2];
  assign o_wreq[2] = bus2.avs_waitrequest; assign o_rdv[2] = bus2.avs_readdatavalid; assign o_rdata[2] = bus2.avs_readdata;

  pkt_mem_agent #(.AW_WORDS(10), .WAIT_STATES(0)) dut0 (
    .clk(clk), .reset(reset), .bus(bus0), .beats_written(o_bw[0]), .beats_read(o_br[0]),
    .proto_err(o_perr[0]), .state_dbg(o_state[0]));
  pkt_mem_agent #(.AW_WORDS(4), .WAIT_STATES(0)) dut1 (
    .clk(clk), .reset(reset), .bus(bus1), .beats_written(o_bw[1]), .beats_read(o_br[1]),
    .proto_err(o_perr[1]), .state_dbg(o_state[1]));
  pkt_mem_agent #(.AW_WORDS(10), .WAIT_STATES(3)) dut2 (
    .clk(clk), .reset(reset), .bus(bus2), .beats_written(o_bw[2]), .beats_read(o_br[2]),
    .proto_err(o_perr[2]), .state_dbg(o_state[2]));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // ---------------- behavioural model: timing expressed as "next edge a command may land"
  logic [31:0] m_mem     [3][1024];
  longint      m_ready   [3];
  int          m_wr_left [3];
  int          m_wr_ptr  [3];
  int          m_rd_left [3];
  int          m_rd_ptr  [3];
  int          m_bw      [3];
  int          m_br      [3];
  logic        m_perr    [3];

  task automatic model_step(input int i, input longint c);
    int depth, ws, idx, n;
    logic e_wreq, e_rdv;
    logic [31:0] e_data;
    depth  = (i == 1) ? 16 : 1024;
    ws     = (i == 2) ? 3 : 0;
    idx    = int'(a_addr[i][31:2]) % depth;
    n      = (a_bc[i] == 16'd0) ? 1 : int'(a_bc[i]);
    e_rdv  = 1'b0;
    e_data = '0;
    if (reset) begin
      m_wr_left[i] = 0; m_rd_left[i] = 0; m_bw[i] = 0; m_br[i] = 0; m_perr[i] = 1'b0;
      m_ready[i] = c + 2 + ws;
      e_wreq = 1'b1;
    end else begin
      if (m_rd_left[i] > 0) begin
        e_rdv = 1'b1;
        e_data = m_mem[i][m_rd_ptr[i]];
        m_rd_ptr[i] = (m_rd_ptr[i] + 1) % depth;
        m_rd_left[i]--;
        m_br[i]++;
        if (m_rd_left[i] == 0) m_ready[i] = c + 1 + ws;
      end else if (c >= m_ready[i]) begin
        if (m_wr_left[i] > 0) begin
          if (a_wr[i]) begin
            m_mem[i][m_wr_ptr[i]] = a_wd[i];
            m_wr_ptr[i] = (m_wr_ptr[i] + 1) % depth;
            m_wr_left[i]--;
            m_bw[i]++;
            if (m_wr_left[i] == 0) m_ready[i] = c + 1 + ws;
          end
        end else if (a_rd[i] && a_wr[i]) begin
          m_perr[i] = 1'b1;
        end else if (a_wr[i]) begin
          m_mem[i][idx] = a_wd[i];
          m_bw[i]++;
          m_wr_ptr[i] = (idx + 1) % depth;
          m_wr_left[i] = n - 1;
          if (n == 1) m_ready[i] = c + 1 + ws;
        end else if (a_rd[i]) begin
          m_rd_ptr[i] = idx;
          m_rd_left[i] = n;
        end
      end
      e_wreq = (m_rd_left[i] > 0) || (c + 1 < m_ready[i]);
    end
    chk($sformatf("d%0d_waitrequest", i), {31'd0, o_wreq[i]}, {31'd0, e_wreq});
    chk($sformatf("d%0d_readdatavalid", i), {31'd0, o_rdv[i]}, {31'd0, e_rdv});
    if (e_rdv) chk($sformatf("d%0d_readdata", i), o_rdata[i], e_data);
    chk($sformatf("d%0d_beats_written", i), o_bw[i], 32'(m_bw[i]));
    chk($sformatf("d%0d_beats_read", i), o_br[i], 32'(m_br[i]));
    chk($sformatf("d%0d_proto_err", i), {31'd0, o_perr[i]}, {31'd0, m_perr[i]});
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      m_ready[i] = 2; m_wr_left[i] = 0; m_rd_left[i] = 0; m_wr_ptr[i] = 0; m_rd_ptr[i] = 0;
      m_bw[i] = 0; m_br[i] = 0; m_perr[i] = 1'b0;
    end
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      for (int i = 0; i < 3; i++) model_step(i, cyc);
    end
  end

  // ---------------- driver tasks: called and returning at a falling edge
  task automatic wait_ready(input int i);
    int t = 0;
    while (o_wreq[i] && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk($sformatf("d%0d_accept", i), {31'd0, o_wreq[i]}, 32'd0);
  endtask

  task automatic do_write(input int i, input logic [31:0] addr, input int n, input logic [31:0] d0,
                          input int stall_at, input int stall_len);
    for (int j = 0; j < n; j++) begin
      if (j == stall_at && stall_len > 0) begin
        a_wr[i] = 1'b0;
        repeat (stall_len) @(negedge clk);
      end
      a_addr[i] = addr; a_bc[i] = 16'(n); a_wd[i] = d0 + 32'(j); a_wr[i] = 1'b1;
      wait_ready(i);
      @(negedge clk);
    end
    a_wr[i] = 1'b0;
  endtask

  task automatic do_read(input int i, input logic [31:0] addr, input int n);
    a_addr[i] = addr; a_bc[i] = 16'(n); a_rd[i] = 1'b1;
    wait_ready(i);
    @(negedge clk);
    a_rd[i] = 1'b0;
  endtask

  // Starts right after the acceptance edge: beats must follow on the very next cycles, back to back.
  task automatic expect_beats(input int i, input logic [31:0] d0, input int n);
    chk($sformatf("d%0d_no_beat_at_accept", i), {31'd0, o_rdv[i]}, 32'd0);
    for (int j = 0; j < n; j++) begin
      @(negedge clk);
      chk($sformatf("d%0d_beat%0d_valid", i, j), {31'd0, o_rdv[i]}, 32'd1);
      chk($sformatf("d%0d_beat%0d_data", i, j), o_rdata[i], d0 + 32'(j));
    end
    @(negedge clk);
    chk($sformatf("d%0d_burst_end", i), {31'd0, o_rdv[i]}, 32'd0);
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    longint acc1, acc2, first;
    int n_hi, t;
    for (int i = 0; i < 3; i++) begin
      a_addr[i] = '0; a_rd[i] = 1'b0; a_wr[i] = 1'b0; a_wd[i] = '0; a_bc[i] = 16'd1;
    end
    @(negedge clk);
    chk("reset_waitrequest", {31'd0, o_wreq[0]}, 32'd1);
    chk("reset_readdatavalid", {31'd0, o_rdv[0]}, 32'd0);
    chk("reset_readdata", o_rdata[0], 32'd0);
    chk("reset_beats_written", o_bw[0], 32'd0);
    chk("reset_proto_err", {31'd0, o_perr[0]}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    // Release: WAIT_STATES=0 opens after one edge, WAIT_STATES=3 after four.
    @(negedge clk);
    chk("release_ws0_open", {31'd0, o_wreq[0]}, 32'd0);
    n_hi = 0;
    while (o_wreq[2] && n_hi < 50) begin
      n_hi++;
      @(negedge clk);
    end
    chk("release_ws3_wait_cycles", 32'(n_hi), 32'd3);

    // Single write then read, plus burstcount 0 behaving as 1.
    apply_reset();
    do_write(0, 32'h10, 1, 32'hDEADBEEF, -1, 0);
    do_read(0, 32'h10, 1);
    expect_beats(0, 32'hDEADBEEF, 1);
    chk("t1_beats_written", o_bw[0], 32'd1);
    chk("t1_beats_read", o_br[0], 32'd1);
    do_read(0, 32'h13, 0);
    expect_beats(0, 32'hDEADBEEF, 1);

    // Burst write with a two-cycle host stall between beats 2 and 3.
    apply_reset();
    do_write(0, 32'h0, 4, 32'd1, 2, 2);
    do_read(0, 32'h0, 4);
    expect_beats(0, 32'd1, 4);
    chk("t2_beats_written", o_bw[0], 32'd4);
    chk("t2_beats_read", o_br[0], 32'd4);

    // Wrap-around in a 16-word RAM: words 15, 0, 1; upper and low address bits ignored.
    apply_reset();
    do_write(1, 32'h0000_0F3F, 3, 32'hA0, -1, 0);
    do_read(1, 32'h3C, 3);
    expect_beats(1, 32'hA0, 3);
    do_read(1, 32'h0, 2);
    expect_beats(1, 32'hA1, 2);

    // WAIT_STATES=3 with the host holding read high for two back-to-back commands.
    apply_reset();
    do_write(2, 32'h100, 4, 32'h50, -1, 0);
    a_addr[2] = 32'h100; a_bc[2] = 16'd4; a_rd[2] = 1'b1;
    wait_ready(2);
    acc1 = cyc + 1;
    @(negedge clk);
    n_hi = 0;
    while (o_wreq[2] && n_hi < 50) begin
      n_hi++;
      @(negedge clk);
    end
    chk("t4_waitrequest_high_cycles", 32'(n_hi), 32'd7);
    acc2 = cyc + 1;
    @(negedge clk);
    a_rd[2] = 1'b0;
    t = 0;
    while (!o_rdv[2] && t < 50) begin
      t++;
      @(negedge clk);
    end
    first = cyc;
    chk("t4_command_gap", 32'(acc2 - acc1), 32'd8);
    chk("t4_second_first_beat", 32'(first - acc1), 32'd9);
    chk("t4_second_first_data", o_rdata[2], 32'h50);
    repeat (6) @(negedge clk);

    // Read and write together in IDLE.
    apply_reset();
    do_write(0, 32'h40, 1, 32'h1111_1111, -1, 0);
    a_addr[0] = 32'h40; a_bc[0] = 16'd1; a_wd[0] = 32'h0000_0BAD; a_rd[0] = 1'b1; a_wr[0] = 1'b1;
    wait_ready(0);
    @(negedge clk);
    a_rd[0] = 1'b0; a_wr[0] = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("t5_no_readdatavalid", {31'd0, o_rdv[0]}, 32'd0);
    end
    chk("t5_proto_err", {31'd0, o_perr[0]}, 32'd1);
    chk("t5_beats_written", o_bw[0], 32'd1);
    chk("t5_beats_read", o_br[0], 32'd0);
    do_read(0, 32'h40, 1);
    expect_beats(0, 32'h1111_1111, 1);
    chk("t5_proto_err_sticky", {31'd0, o_perr[0]}, 32'd1);

    // Reset during beat 3 of an 8-beat read.
    apply_reset();
    do_write(0, 32'h200, 8, 32'h700, -1, 0);
    do_read(0, 32'h200, 8);
    repeat (3) @(negedge clk);
    chk("t6_beat3_valid", {31'd0, o_rdv[0]}, 32'd1);
    chk("t6_beat3_data", o_rdata[0], 32'h702);
    reset = 1'b1;
    #1;
    chk("t6_async_readdatavalid", {31'd0, o_rdv[0]}, 32'd0);
    chk("t6_async_waitrequest", {31'd0, o_wreq[0]}, 32'd1);
    chk("t6_async_beats_written", o_bw[0], 32'd0);
    chk("t6_async_beats_read", o_br[0], 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    do_read(0, 32'h200, 8);
    expect_beats(0, 32'h700, 8);
    chk("t6_reread_beats_read", o_br[0], 32'd8);

    repeat (4) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
